// File: rtl/wb_arb_pkg.sv
// wb_arb shared types: channel index, FSM state, one-hot helper.
// Build option WB_ARB_M_PRIO_EN is consumed by wb_arb, not here.
package wb_arb_pkg;

  localparam int NREQ = 5;
  localparam int CH_M = 4;

  typedef logic [2:0] ch_t;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  function automatic logic [NREQ-1:0] onehot(
    input ch_t id
  );
    logic [NREQ-1:0] v;
    for (int i = 0; i < NREQ; i++) begin
      v[i] = (id == ch_t'(i));
    end
    return v;
  endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// rr_pick: combinational rotating-priority encoder.
// Ports: req/last in; winner = first req after last, valid = |req.
module rr_pick
  import wb_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  ch_t             last,
  output ch_t             winner,
  output logic            valid
);

  int idx;

  // Scan farthest-first so the nearest requester after
  // last is the final (winning) assignment.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (req[idx[2:0]]) begin
        winner = idx[2:0];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arb.sv
// wb_arb: 5-way round-robin bus arbiter with burst preemption
// and slave watchdog. Ports: wb_clk_i, wb_rst_i (sync, low),
// req[4:0], wbm_ack_i/err_i/rty_i in; gnt[4:0], busy, tmo,
// tmo_id[2:0] out (all registered).
// Option WB_ARB_M_PRIO_EN: channel 4 (M) wins in IDLE, is
// never burst-preempted and does not move the RR pointer.
module wb_arb
  import wb_arb_pkg::*;
#(
  parameter int BURST_MAX = 16,
  parameter int TMO_W     = 8,
  parameter int TMO_MAX   = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [NREQ-1:0] req,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i,
  input  logic            wbm_rty_i,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic            tmo,
  output ch_t             tmo_id
);

  state_t           state;
  ch_t              owner;
  ch_t              last;
  logic [7:0]       beats;
  logic [TMO_W-1:0] wdog;

  ch_t  rr_win;
  logic rr_ok;
  ch_t  pick;
  logic can_preempt;
  logic upd_last;
  logic resp;
  logic others;
  logic drop;
  logic burst_hit;
  logic tmo_hit;

  rr_pick u_pick (
    .req    (req),
    .last   (last),
    .winner (rr_win),
    .valid  (rr_ok)
  );

`ifdef WB_ARB_M_PRIO_EN
  assign pick        = req[CH_M] ? ch_t'(CH_M) : rr_win;
  assign can_preempt = (owner != ch_t'(CH_M));
  assign upd_last    = (pick != ch_t'(CH_M));
`else
  assign pick        = rr_win;
  assign can_preempt = 1'b1;
  assign upd_last    = 1'b1;
`endif

  assign resp   = wbm_ack_i | wbm_err_i | wbm_rty_i;
  assign others = |(req & ~onehot(owner));
  assign drop   = !req[owner];

  // Preempt only on the ack that completes the budget.
  assign burst_hit = can_preempt && wbm_ack_i && others
                  && (beats == 8'(BURST_MAX - 1));

  // Any slave response in this cycle cancels the timeout.
  assign tmo_hit = !resp
                && (wdog == TMO_W'(TMO_MAX - 1));

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state  <= IDLE;
      gnt    <= '0;
      busy   <= 1'b0;
      tmo    <= 1'b0;
      tmo_id <= '0;
      owner  <= '0;
      last   <= ch_t'(CH_M);
      beats  <= '0;
      wdog   <= '0;
    end else begin
      tmo <= 1'b0;
      unique case (state)
        IDLE: begin
          gnt  <= '0;
          busy <= 1'b0;
          if (rr_ok) begin
            state <= GRANT;
            gnt   <= onehot(pick);
            busy  <= 1'b1;
            owner <= pick;
            beats <= '0;
            wdog  <= '0;
            if (upd_last) begin
              last <= pick;
            end
          end
        end
        GRANT: begin
          // Every exit lands in IDLE: one dead
          // cycle for the mixer handoff.
          if (drop || burst_hit) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end else if (tmo_hit) begin
            state  <= IDLE;
            gnt    <= '0;
            busy   <= 1'b0;
            tmo    <= 1'b1;
            tmo_id <= owner;
          end else begin
            if (wbm_ack_i
                && beats != 8'(BURST_MAX)) begin
              beats <= beats + 8'd1;
            end
            if (resp) begin
              wdog <= '0;
            end else begin
              wdog <= wdog + TMO_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arb.sv
// tb_wb_arb: scoreboard bench for wb_arb.
// Directed scenarios then random traffic against a spec model.
module tb_wb_arb;

  localparam int BMAX = 16;
  localparam int TMAX = 255;

  typedef struct packed {
    logic [4:0] gnt;
    logic       busy;
    logic       tmo;
    logic [2:0] tmo_id;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [4:0] req;
  logic       ack;
  logic       err;
  logic       rty;
  logic [4:0] gnt;
  logic       busy;
  logic       tmo;
  logic [2:0] tmo_id;

  exp_t expq[$];
  int   n_tests;
  int   n_fail;
  int   n_cyc;

  // Spec-level model state
  bit m_grant;
  int m_owner;
  int m_last;
  int m_beats;
  int m_wd;
  bit m_tmo;
  int m_tmo_id;

  wb_arb dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst_n),
    .req       (req),
    .wbm_ack_i (ack),
    .wbm_err_i (err),
    .wbm_rty_i (rty),
    .gnt       (gnt),
    .busy      (busy),
    .tmo       (tmo),
    .tmo_id    (tmo_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_prio();
`ifdef WB_ARB_M_PRIO_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_step(
    input bit rs, input logic [4:0] r,
    input bit a, input bit e, input bit y
  );
    int  w;
    bit  oth;
    if (!rs) begin
      m_grant  = 0;
      m_owner  = 0;
      m_last   = 4;
      m_beats  = 0;
      m_wd     = 0;
      m_tmo    = 0;
      m_tmo_id = 0;
      return;
    end
    m_tmo = 0;
    if (!m_grant) begin
      if (r != 0) begin
        w = -1;
        if (m_prio() && r[4]) w = 4;
        for (int k = 1; k <= 5 && w < 0; k++)
          if (r[(m_last + k) % 5]) w = (m_last + k) % 5;
        m_grant = 1;
        m_owner = w;
        m_beats = 0;
        m_wd    = 0;
        if (!(m_prio() && w == 4)) m_last = w;
      end
    end else begin
      oth = (r & ~(5'd1 << m_owner)) != 0;
      if (!r[m_owner]) begin
        m_grant = 0;
      end else if (m_beats == BMAX - 1 && a && oth
                   && !(m_prio() && m_owner == 4)) begin
        m_grant = 0;
      end else if (m_wd == TMAX - 1 && !(a || e || y)) begin
        m_grant  = 0;
        m_tmo    = 1;
        m_tmo_id = m_owner;
      end else begin
        if (a && m_beats < BMAX) m_beats++;
        if (a || e || y) m_wd = 0;
        else m_wd++;
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t x;
    x.gnt    = m_grant ? (5'd1 << m_owner) : 5'd0;
    x.busy   = m_grant;
    x.tmo    = m_tmo;
    x.tmo_id = 3'(m_tmo_id);
    return x;
  endfunction

  task automatic drive(
    input bit rs, input logic [4:0] r,
    input bit a, input bit e, input bit y
  );
    @(negedge clk);
    rst_n = rs;
    req   = r;
    ack   = a;
    err   = e;
    rty   = y;
    model_step(rs, r, a, e, y);
    expq.push_back(model_out());
  endtask

  // Monitor: compare every registered output set one
  // step after the edge that produced it.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      n_cyc++;
      if (expq.size() != 0) begin
        x = expq.pop_front();
        n_tests++;
        if ({gnt, busy, tmo, tmo_id} !== x) begin
          n_fail++;
          $display("FAIL outputs cyc=%0d got gnt=%b busy=%b tmo=%b id=%0d exp gnt=%b busy=%b tmo=%b id=%0d",
                   n_cyc, gnt, busy, tmo, tmo_id,
                   x.gnt, x.busy, x.tmo, x.tmo_id);
        end
        n_tests++;
        if ($countones(gnt) > 1) begin
          n_fail++;
          $display("FAIL onehot cyc=%0d got gnt=%b exp at most one bit",
                   n_cyc, gnt);
        end
      end
    end
  end

  initial begin
    logic [4:0] r;
    bit         a;
    bit         e;
    bit         y;
    bit         rs;
    n_tests = 0;
    n_fail  = 0;
    n_cyc   = 0;
    rst_n   = 1'b0;
    req     = '0;
    ack     = 1'b0;
    err     = 1'b0;
    rty     = 1'b0;

    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    // Round-robin 0 -> 2 -> 4, released by req drop
    r = 5'b10101;
    for (int g = 0; g < 3; g++) begin
      drive(1, r, 0, 0, 0);
      drive(1, r, 0, 0, 0);
      drive(1, r, 0, 0, 0);
      r[m_owner] = 1'b0;
      drive(1, r, 0, 0, 0);
    end
    drive(1, 0, 0, 0, 0);

    // Burst budget with and without a waiting peer
    for (int pass = 0; pass < 2; pass++) begin
      r = 5'b00100;
      drive(1, r, 0, 0, 0);
      for (int k = 1; k <= 20; k++) begin
        if (pass == 0 && k >= 3) r[0] = 1'b1;
        drive(1, r, 1, 0, 0);
      end
      drive(1, r, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
    end

    // Watchdog: silent slave, then ack in cycle 254
    for (int pass = 0; pass < 2; pass++) begin
      r = 5'b00010;
      drive(1, r, 0, 0, 0);
      for (int k = 1; k <= 258; k++)
        drive(1, r, (pass == 1 && k == 254), 0, 0);
      drive(1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
    end

    // Reset mid-grant, then all request
    r = 5'b01000;
    drive(1, r, 0, 0, 0);
    repeat (4) drive(1, r, 1, 0, 0);
    drive(0, r, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 5'b11111, 0, 0, 0);
    repeat (3) drive(1, 5'b11111, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    // Channel M priority scenario (last=1 first)
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 5'b00010, 0, 0, 0);
    drive(1, 5'b00010, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    r = 5'b11100;
    drive(1, r, 0, 0, 0);
    drive(1, r, 0, 0, 0);
    r[4] = 1'b0;
    drive(1, r, 0, 0, 0);
    drive(1, r, 0, 0, 0);
    drive(1, r, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    // Random traffic with quiet windows for the watchdog
    r = '0;
    for (int c = 0; c < 4000; c++) begin
      bit quiet;
      quiet = (c % 700) >= 400;
      if (!quiet)
        for (int b = 0; b < 5; b++)
          if ($urandom_range(7) == 0) r[b] = ~r[b];
      a  = !quiet && ($urandom_range(2) == 0);
      e  = !quiet && ($urandom_range(15) == 0);
      y  = !quiet && ($urandom_range(15) == 0);
      rs = ($urandom_range(299) != 0);
      drive(rs, r, a, e, y);
    end

    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending exp 0",
               expq.size());
    end
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arb.md
Name: wb_arb

Overview:
- Five-requester bus arbiter that produces the one-hot gnt[4:0] consumed by the wishbone mixer.
- Requesters are channels 0-3 plus channel M (index 4).
- Grants are round-robin, held for the full bus cycle, preempted after a beat budget when others wait, and revoked by a watchdog if the slave never answers.

Parameters:
- NREQ, 5, number of requesters; fixed by the mixer, not meant to be overridden.
- BURST_MAX, 16, acks allowed per grant while another requester is pending (range 1..255).
- TMO_W, 8, watchdog counter width.
- TMO_MAX, 255, idle-bus cycles before grant revocation (1..2^TMO_W-1).

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  synchronous reset, active-low.
- req  in  5  per-channel request, driven from wbs_cyc0..wbs_cyc4.
- wbm_ack_i  in  1  slave ack.
- wbm_err_i  in  1  slave error.
- wbm_rty_i  in  1  slave retry.
- gnt  out  5  one-hot grant, registered, to the mixer.
- busy  out  1  high while in GRANT.
- tmo  out  1  one-cycle pulse on watchdog revocation.
- tmo_id  out  3  index of the channel revoked; holds until the next timeout.

Behaviour:
- Reset (wb_rst_i low at a clock edge):
  - Outputs: gnt=0, busy=0, tmo=0, tmo_id=0.
  - Internal: state=IDLE, last=4 (so channel 0 has priority first), beat count=0, watchdog=0.
  - Reset asserted mid-GRANT drops gnt on the same edge; no tmo pulse.
- States: IDLE, GRANT.
- IDLE:
  - gnt=0.
  - If req!=0, choose the first requesting index scanning last+1, last+2 ... (mod 5).
  - Next edge: gnt=onehot(winner), owner=winner, last=winner, state=GRANT.
  - Latency req->gnt is one cycle.
- GRANT:
  - gnt held constant.
  - Exit A: req[owner]=0 -> next edge gnt=0, state=IDLE.
  - Exit B: beats==BURST_MAX-1 and wbm_ack_i and (req & ~onehot(owner))!=0 -> preempt; next edge gnt=0, IDLE.
  - Exit C: watchdog==TMO_MAX-1 and none of ack/err/rty in this cycle -> next edge gnt=0, IDLE, tmo=1, tmo_id=owner.
  - Every exit spends at least one IDLE cycle with gnt=0 (mandatory dead cycle for mixer handoff).
- Beat counter:
  - Cleared on entry to GRANT; +1 per wbm_ack_i; saturates at BURST_MAX.
  - At the limit with no other requester pending, no preemption; owner keeps the bus.
- Watchdog:
  - Cleared on entry to GRANT and on any cycle with ack, err or rty.
  - Otherwise increments each GRANT cycle.
- Simultaneous events:
  - Ack in the timeout cycle: ack wins, no timeout.
  - req[owner] drop coinciding with burst limit: treated as exit A.
  - err and rty only clear the watchdog; they do not release the grant.
- gnt is never multi-hot; it is 0 in IDLE.

Optional Feature:
- Macro: WB_ARB_M_PRIO_EN.
- Defined:
  - In IDLE, req[4] wins unconditionally.
  - Channel M is exempt from burst preemption (exit B disabled when owner=4).
  - A grant to M does not update last, so the round-robin order of channels 0-3 is preserved.
- Undefined: channel M is an ordinary round-robin peer.

Decomposition:
- Package wb_arb_pkg:
  - NREQ=5, CH_M=4.
  - State enum {IDLE, GRANT}.
  - Channel-index type (3 bits).
  - onehot() function.
- Sub-module rr_pick: combinational rotating-priority encoder.
  - Inputs: req[4:0], last[2:0].
  - Outputs: winner[2:0], valid.
  - Reused by other arbiters in the block set.

Test Plan:
- After reset, req=5'b10101 held -> gnt sequence 00001, then 00100, then 10000.
  - Each grant released by dropping the owner's req; one gnt=0 cycle between grants.
- req[2] alone, 20 consecutive acks, req[0] asserted from cycle 3 -> gnt=00100 released after the 16th ack; next edge gnt=0; then gnt=00001.
- Same 20-ack burst with no other requester -> gnt=00100 kept for all 20 acks; released only when req[2] drops.
- req[1] granted, no ack/err/rty -> exactly TMO_MAX (255) GRANT cycles, then gnt=0, tmo pulses 1 cycle, tmo_id=1.
  - Repeat with ack on cycle 254 -> no timeout; watchdog restarts.
- wb_rst_i low for 1 cycle mid-grant to channel 3 -> gnt=0, tmo=0 next edge; after release, req=11111 -> channel 0 granted first.
- With WB_ARB_M_PRIO_EN: last=1, req=11100 -> gnt=10000; after M releases -> gnt=00100.
